// File: rtl/seg_scan_pkg.sv
// Shared types and sizing for the 4-digit 7-segment scan controller.
package seg_scan_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned IDX_W      = 2;

  typedef enum logic [0:0] {
    StGuard,
    StOn
  } state_e;

  // Width of a counter that must hold 0..div-1.
  function automatic int unsigned slot_cnt_w(int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Display-value update handshake between a requester and the scan controller.
interface seg_scan_if;
  import seg_scan_pkg::*;

  logic [NUM_DIGITS*BCD_W-1:0] value_in;
  logic [NUM_DIGITS-1:0]       dp_in;
  logic                        update_req;
  logic                        update_ack;

  modport master (
    output value_in,
    output dp_in,
    output update_req,
    input  update_ack
  );

  modport slave (
    input  value_in,
    input  dp_in,
    input  update_req,
    output update_ack
  );

endinterface

// File: rtl/seg_scan_prescaler.sv
// Per-digit slot counter; flags the last guard cycle and the last cycle of each slot.
module seg_scan_prescaler import seg_scan_pkg::*; #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD_CYC   = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  output logic guard_done_o,
  output logic slot_end_o
);

  localparam int unsigned     CntW      = slot_cnt_w(REFRESH_DIV);
  localparam logic [CntW-1:0] LastCnt   = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (enable_i) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Pulses are gated by enable so a frozen counter never re-fires them.
  assign guard_done_o = enable_i && (cnt_q == GuardLast);
  assign slot_end_o   = enable_i && (cnt_q == LastCnt);

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexes four BCD digits onto one shared 7-segment decoder with guard gaps.
// Optional leading-zero blanking is built when SEG_SCAN_LZ_BLANK_EN is defined.
module seg_scan_controller import seg_scan_pkg::*; #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD_CYC   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  seg_scan_if.slave             upd,
  output logic [BCD_W-1:0]      code_out,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  dp_n,
  output logic                  frame_tick
);

  logic guard_done, slot_end;

  seg_scan_prescaler #(
    .REFRESH_DIV(REFRESH_DIV),
    .GUARD_CYC  (GUARD_CYC)
  ) u_prescaler (
    .clk_i       (clk),
    .reset_i     (reset),
    .enable_i    (enable),
    .guard_done_o(guard_done),
    .slot_end_o  (slot_end)
  );

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_DIGITS*BCD_W-1:0] disp_q, disp_d;
  logic [NUM_DIGITS-1:0]       dp_q, dp_d;
  logic                        ack_q;
  logic                        frame_end, load;
  logic [NUM_DIGITS-1:0]       blank;
  logic                        show;
  logic [BCD_W-1:0]            code_d;
  logic [NUM_DIGITS-1:0]       an_d;
  logic                        dp_n_d;

  assign frame_end      = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign load           = frame_end && upd.update_req;
  assign upd.update_ack = ack_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (slot_end) begin
      state_d = StGuard;
      idx_d   = idx_q + 1'b1;
    end else if (guard_done) begin
      state_d = StOn;
    end
    disp_d = load ? upd.value_in : disp_q;
    dp_d   = load ? upd.dp_in : dp_q;
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic lz_run;

  // A digit blanks while it and every digit above it are zero; its own dp lights it anyway.
  always_comb begin
    blank  = '0;
    lz_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run   = lz_run && (disp_d[k*BCD_W +: BCD_W] == '0);
      blank[k] = lz_run && !dp_d[k];
    end
  end
`else
  assign blank = '0;
`endif

  // Outputs are decoded from next-state values so the registered pins line up with the state.
  always_comb begin
    show   = enable && (state_d == StOn) && !blank[idx_d];
    code_d = disp_d[idx_d*BCD_W +: BCD_W];
    an_d   = '1;
    dp_n_d = 1'b1;
    if (show) begin
      an_d[idx_d] = 1'b0;
      dp_n_d      = ~dp_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StGuard;
      idx_q      <= '0;
      disp_q     <= '0;
      dp_q       <= '0;
      ack_q      <= 1'b0;
      frame_tick <= 1'b0;
      code_out   <= '0;
      an_n       <= '1;
      dp_n       <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      dp_q       <= dp_d;
      ack_q      <= load;
      frame_tick <= frame_end;
      code_out   <= code_d;
      an_n       <= an_d;
      dp_n       <= dp_n_d;
    end
  end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
Time-multiplexes the single shared 7-segment decoder across the four stopwatch digits. Each cycle it drives one BCD nibble to the decoder's W,X,Y,Z inputs and enables the matching common-anode digit. A guard interval before each digit suppresses ghosting. New display values are accepted through a req/ack handshake, and only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot; legal range 4..2^20.
GUARD_CYC, 16, cycles at the start of each slot with all anodes off; legal range 1..REFRESH_DIV-2.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = scanning runs; 0 = display dark, counters frozen
value_in  input  16  four BCD digits; [3:0] is digit 0 (rightmost); held stable while update_req=1
dp_in  input  4  decimal-point request per digit, 1 = lit
update_req  input  1  level request to load value_in/dp_in
update_ack  output  1  one-cycle pulse: value loaded
code_out  output  4  nibble to decoder {W,X,Y,Z} for the active digit
an_n  output  4  active-low anode enables, one-hot-low or all 1
dp_n  output  1  active-low decimal point for the active digit
frame_tick  output  1  one-cycle pulse on the wrap from digit 3 to digit 0

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - slot counter 0, digit index 0, state GUARD;
  - display_reg 16'h0000, dp_reg 4'b0000;
  - an_n 4'b1111, dp_n 1, code_out 4'h0, update_ack 0, frame_tick 0.
  - Reset asserted mid-slot or mid-handshake aborts the operation immediately. A pending request is re-sampled after reset.
- Slot counter runs 0..REFRESH_DIV-1 while enable=1. The terminal count ends the slot.
- FSM, two states:
  - GUARD (slot count < GUARD_CYC): an_n = 4'b1111, dp_n = 1. code_out already shows the new digit so the decoder settles.
  - ON (remaining cycles): an_n[idx] = 0, all others 1; dp_n = ~dp_reg[idx].
  - GUARD -> ON when slot count reaches GUARD_CYC.
  - ON -> GUARD at terminal count; idx advances (idx+1) mod 4.
- code_out = display_reg[4*idx+3 : 4*idx]. Any nibble 0..F is passed through unmodified.
- Frame boundary = terminal count with idx=3.
  - In that cycle: frame_tick=1 next cycle, idx wraps to 0.
  - If update_req=1 in that cycle: display_reg <= value_in, dp_reg <= dp_in, update_ack=1 in the next cycle.
- Handshake:
  - Requester holds update_req and data until it sees ack, then drops update_req.
  - If update_req is still high at the next frame boundary, a further load and ack occur (level-sensitive, one load per frame maximum).
  - update_req=0 at the boundary: display_reg is unchanged, no ack.
- enable=0:
  - an_n = 4'b1111, dp_n = 1;
  - slot counter, idx, state and display_reg are held;
  - no loads, no ack, no frame_tick.
  - On re-enable, scanning resumes from the held position.
- enable falling in the same cycle as a frame boundary: the boundary does not take effect (enable gates it).

Optional Feature:
Macro: SEG_SCAN_LZ_BLANK_EN.
- Defined: leading-zero blanking. Digit k (k = 3, 2, 1) is blanked when it and every higher digit of display_reg is 4'h0. Digit 0 is never blanked. A blanked digit keeps an_n all 1 for its whole slot and dp_n = 1, unless dp_reg[k] = 1, which overrides blanking for that digit. Blank flags are recomputed from display_reg each cycle.
- Undefined: every digit is shown in its ON phase, leading zeros included.

Decomposition:
- Package seg_scan_pkg:
  - state enum {GUARD, ON};
  - NUM_DIGITS = 4, BCD_W = 4, IDX_W = 2;
  - function clog2-based slot counter width.
- Sub-module seg_scan_prescaler: slot counter with enable. Outputs guard_done and slot_end pulses. The FSM, display registers and handshake stay in the top.

Test Plan:
- REFRESH_DIV=8, GUARD_CYC=2, enable=1 after reset:
  - cycles 0-1 of each slot: an_n = 1111;
  - cycles 2-7: an_n = 1110, 1101, 1011, 0111 in successive slots;
  - frame_tick every 32 cycles.
- Handshake: value_in = 16'h1234, dp_in = 4'b0100, raise update_req mid-frame.
  - No change until the frame boundary; update_ack pulses once the cycle after the boundary.
  - Next frame: code_out = 4, 3, 2, 1 for idx 0..3; dp_n = 0 only in digit 2's ON phase.
- Held update_req across two boundaries with value_in changing 16'h0001 -> 16'h0002:
  - two ack pulses, 32 cycles apart;
  - display_reg updates at each boundary.
- enable dropped mid-ON of digit 2 for 10 cycles: an_n = 1111 throughout. On re-enable, digit 2 finishes its remaining ON cycles; the slot length is preserved.
- Reset asserted in the cycle of the frame boundary with update_req=1:
  - no ack; display_reg = 0;
  - the load occurs at the first boundary after reset.
- With SEG_SCAN_LZ_BLANK_EN, value 16'h0050, dp 0:
  - digits 3 and 2 stay dark for their whole slots;
  - digits 1 and 0 show 5 and 0.
  - Set dp_in[3] = 1: digit 3 lights, code 0.
